// File: rtl/sp_ram_ctrl_pkg.sv
// sp_ram_pkg: shared defaults and the controller state encoding.
//   DATA_W / ADDR_W / DEPTH / INIT_VALUE : default geometry and init word
//   state_t                              : INIT (power-up sweep), RUN (serving requests)
package sp_ram_pkg;
    localparam int          DATA_W     = 32;
    localparam int          ADDR_W     = 10;
    localparam int          DEPTH      = 2 ** ADDR_W;
    localparam logic [31:0] INIT_VALUE = 32'h0000_0000;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/sp_ram_ctrl_if.sv
// sp_ram_ctrl_if: request/response bus of the single-port RAM controller.
//   req_valid/req_ready/req_we/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata                 : read response channel
//   master : requester side, slave : controller side
interface sp_ram_ctrl_if #(
    parameter int DATA_W = sp_ram_pkg::DATA_W,
    parameter int ADDR_W = sp_ram_pkg::ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sp_ram.sv
// sp_ram: single-port synchronous RAM, registered read (q valid one cycle
// after addr). A write updates the array at the edge, so a read of the same
// address on the following cycle sees the new word.
//   clk, we, addr, data : write/read port
//   q                   : registered read data
module sp_ram #(
    parameter int DATA_W = sp_ram_pkg::DATA_W,
    parameter int ADDR_W = sp_ram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= data;
        q <= mem[addr];
    end
endmodule

// File: rtl/sp_ram_ctrl_rsp_fifo.sv
// sp_ram_rsp_fifo: 2-entry response buffer.
//   clk, rst_n : clock, async active-low reset (empties the buffer)
//   push/wdata : enqueue
//   pop/rdata  : dequeue, rdata is the current head
//   count      : occupancy 0..2
module sp_ram_rsp_fifo #(
    parameter int DATA_W = sp_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem [2];
    logic              wptr;
    logic              rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rdata = mem[rptr];

    // The controller's admission rule makes both of these unreachable.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count == 2'd0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count == 2'd2));
endmodule

// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: front end for a single-port RAM.
// After reset it sweeps INIT_VALUE into every word (INIT), then serves
// read/write requests (RUN). Reads return in order through a 2-entry FIFO,
// with a bypass from ram_q so an empty FIFO answers one cycle after accept.
//   clk, rst_n  : clock, async active-low reset
//   bus (slave) : request/response channel
//   init_done   : high from the first RUN cycle
//   ram_*       : drive/observe the sp_ram instance
module sp_ram_ctrl #(
    parameter int                              DATA_W     = sp_ram_pkg::DATA_W,
    parameter int                              ADDR_W     = sp_ram_pkg::ADDR_W,
    parameter logic [sp_ram_pkg::DATA_W-1:0]   INIT_VALUE = sp_ram_pkg::INIT_VALUE
) (
    input  logic              clk,
    input  logic              rst_n,
    sp_ram_ctrl_if.slave      bus,
    output logic              init_done,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);
    import sp_ram_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              rd_inflight;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              req_ready;
    logic              accept;
    logic              rd_acc;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            cnt         <= '0;
            rd_inflight <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
            rd_inflight <= rd_acc;
        end
    end

    // fifo_count + rd_inflight is the number of reads accepted but not yet
    // consumed; capping it at 2 guarantees every in-flight read has a slot.
    assign req_ready = (state == RUN) &&
                       (({1'b0, fifo_count} + {2'b00, rd_inflight}) < 3'd2);
    assign accept    = bus.req_valid & req_ready;
    assign rd_acc    = accept & ~bus.req_we;

    always_comb begin
        if (state == INIT) begin
            ram_we   = 1'b1;
            ram_addr = cnt;
            ram_data = INIT_VALUE[DATA_W-1:0];
        end else begin
            ram_we   = accept & bus.req_we;
            ram_addr = bus.req_addr;
            ram_data = bus.req_wdata;
        end
    end

    // With an empty FIFO the in-flight word is shown straight from ram_q; if
    // it is taken that cycle it never enters the FIFO. Otherwise it is queued
    // behind the head, which keeps rsp_rdata steady under backpressure.
    assign bypass    = rd_inflight & (fifo_count == 2'd0);
    assign fifo_push = rd_inflight & ~(bypass & bus.rsp_ready);
    assign fifo_pop  = bus.rsp_ready & (fifo_count != 2'd0);

    sp_ram_rsp_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (ram_q),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (fifo_count != 2'd0) | rd_inflight;
    assign bus.rsp_rdata = (fifo_count != 2'd0) ? fifo_head :
                           (bypass ? ram_q : '0);
endmodule

// File: tb/tb_sp_ram_ctrl.sv
// tb_sp_ram_ctrl: drives sp_ram_ctrl + sp_ram and compares every cycle
// against a transaction-level model (word array + queue of owed read data).
module tb_sp_ram_ctrl;
    localparam int          DW    = 32;
    localparam int          AW    = 10;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] IV    = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;

    always #5 clk = ~clk;

    sp_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sp_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .INIT_VALUE(IV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    sp_ram #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .data (ram_data),
        .q    (ram_q)
    );

    // reference model
    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            sweep;
    bit            run;
    bit            last_acc;
    int            dut_pops;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        run   = 1'b0;
        sweep = 0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = IV;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        bit rdy;
        bit acc;
        bit pop;
        #1;
        rdy = run && (exp_q.size() < 2);
        chk("init_done", init_done, run);
        chk("req_ready", bus.req_ready, rdy);
        chk("rsp_valid", bus.rsp_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) chk("rsp_rdata", bus.rsp_rdata, exp_q[0]);
        if (!run) begin
            chk("sweep_we", ram_we, 1'b1);
            chk("sweep_addr", ram_addr, sweep);
            chk("sweep_data", ram_data, IV);
        end else begin
            chk("ram_we", ram_we, bus.req_valid && rdy && bus.req_we);
        end
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready) dut_pops++;
        acc = bus.req_valid && rdy;
        pop = (exp_q.size() > 0) && bus.rsp_ready;
        @(posedge clk);
        if (!run) begin
            sweep++;
            if (sweep == DEPTH) run = 1'b1;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                if (bus.req_we) mdl_mem[bus.req_addr] = bus.req_wdata;
                else exp_q.push_back(mdl_mem[bus.req_addr]);
            end
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, '0);
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic finish_sweep();
        bus.req_valid = 1'b0;
        while (!run) step();
    endtask

    // Hold one request until the model says it was taken.
    task automatic issue(input bit we_i, input int a_i, input logic [DW-1:0] d_i);
        int k;
        logic [31:0] a32;
        a32 = a_i;
        bus.req_valid = 1'b1;
        bus.req_we    = we_i;
        bus.req_addr  = a32[AW-1:0];
        bus.req_wdata = d_i;
        for (k = 0; k < 64; k++) begin
            step();
            if (last_acc) break;
        end
        if (k == 64) chk("issue_timeout", 1'b0, 1'b1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (k = 0; k < 16 && exp_q.size() > 0; k++) step();
        if (k == 16) chk("drain_timeout", 1'b0, 1'b1);
        chk("drain_empty", bus.rsp_valid, 1'b0);
    endtask

    logic [DW-1:0] wr_words [16];

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        last_acc      = 1'b0;
        dut_pops      = 0;
        mdl_reset();
        @(negedge clk);

        // reset, full sweep, initial contents
        do_reset();
        finish_sweep();
        bus.rsp_ready = 1'b1;
        issue(1'b0, 0, '0);
        issue(1'b0, 511, '0);
        issue(1'b0, 1023, '0);
        drain();

        // 16 writes then 16 back-to-back reads
        for (int i = 0; i < 16; i++) begin
            wr_words[i] = $urandom;
            issue(1'b1, i, wr_words[i]);
        end
        dut_pops = 0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, i, '0);
            chk("b2b_accept", last_acc, 1'b1);
        end
        drain();
        chk("b2b_rsp_count", dut_pops, 16);

        // backpressure: two reads fill the window, third waits
        bus.rsp_ready = 1'b0;
        issue(1'b0, 3, '0);
        issue(1'b0, 7, '0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'd12;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_ready", bus.req_ready, 1'b0);
            chk("stall_rdata", bus.rsp_rdata, wr_words[3]);
        end
        bus.rsp_ready = 1'b1;
        issue(1'b0, 12, '0);
        drain();

        // write then immediate read of the same word
        issue(1'b1, 5, 32'hDEAD_BEEF);
        issue(1'b0, 5, '0);
        chk("raw_head", bus.rsp_rdata, 32'hDEAD_BEEF);
        drain();

        // reset mid-sweep at address 300
        do_reset();
        while (sweep < 300) idle();
        chk("mid_sweep_addr", ram_addr, 300);
        do_reset();
        idle();
        finish_sweep();

        // reset with two responses pending
        issue(1'b1, 20, 32'h1234_5678);
        bus.rsp_ready = 1'b0;
        issue(1'b0, 20, '0);
        issue(1'b0, 20, '0);
        idle();
        do_reset();
        finish_sweep();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) idle();
        issue(1'b0, 20, '0);
        drain();

        // random traffic
        for (int c = 0; c < 10000; c++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_we    = $urandom_range(0, 1);
            bus.req_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
            bus.req_wdata = $urandom;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sp_ram_ctrl.md
SP_RAM_CTRL -- requirements
Module: sp_ram_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of the data and RAM words.
REQ-002 Parameter ADDR_W, default 10, address width; DEPTH = 2**ADDR_W = 1024.
REQ-003 Parameter INIT_VALUE, default 32'h0000_0000, word written to every location by the init sweep.
REQ-004 clk  input  1  single clock; every flop shall be rising-edge triggered.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  request address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  consumer takes the response.
REQ-013 rsp_rdata  output  DATA_W  read data.
REQ-014 init_done  output  1  init sweep complete.
REQ-015 ram_data  output  DATA_W  to sp_ram data.
REQ-016 ram_addr  output  ADDR_W  to sp_ram addr.
REQ-017 ram_we  output  1  to sp_ram we.
REQ-018 ram_q  input  DATA_W  from sp_ram q; valid one cycle after the read address is presented.

Function
REQ-019 FSM states: INIT and RUN; reset entry state shall be INIT.
- INIT: an address counter runs 0..DEPTH-1, one write per cycle.
  - ram_we=1, ram_addr=counter, ram_data=INIT_VALUE.
  - After address DEPTH-1 is written, the FSM shall go to RUN.
  - The sweep shall take exactly 1024 cycles; init_done shall rise on the first RUN cycle.
- RUN: the FSM shall stay in RUN until reset.
REQ-020 In INIT, req_ready shall be 0.
REQ-021 In RUN: req_ready = (fifo_count + rd_inflight < 2), where
- rd_inflight is 1 when a read was accepted in the previous cycle;
- fifo_count is the occupancy of the 2-entry response FIFO.
REQ-022 In RUN, the RAM ports shall combinationally pass the request:
- ram_addr=req_addr and ram_data=req_wdata;
- ram_we = req_valid & req_ready & req_we.
REQ-023 A read accepted in cycle N shall push ram_q into the response FIFO at the end of cycle N+1.
- rsp_valid shall be high in cycle N+1 at the earliest (FIFO empty, read data bypassed from ram_q).
- rsp_valid shall be high no later than cycle N+2 otherwise.
REQ-024 Accepted writes shall produce no response.
REQ-025 Responses shall be returned in request order; rsp_rdata shall be the FIFO head and rsp_valid = (fifo_count != 0) or bypass.
REQ-026 A FIFO push and pop in the same cycle shall leave the count unchanged.
REQ-027 Pop when the FIFO is empty and push when it is full shall be impossible by construction; an assertion shall flag either.
REQ-028 A write to address A in cycle N followed by a read of A in cycle N+1 shall return the new data.
REQ-029 rsp_rdata shall hold stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-030 Asserting rst_n low at any time, including mid-sweep or with responses pending, shall asynchronously return the block to its reset state:
- FSM=INIT, counter=0, FIFO empty, rd_inflight=0;
- init_done=0, rsp_valid=0, req_ready=0, rsp_rdata=0.
REQ-031 After rst_n deasserts, the full init sweep shall restart from address 0; pending responses shall be discarded.

Structure
REQ-032 Package sp_ram_pkg shall hold DATA_W, ADDR_W, DEPTH, INIT_VALUE defaults and the state enum {INIT, RUN}.
REQ-033 The response buffer shall be a sub-module sp_ram_rsp_fifo: 2 entries, DATA_W wide, with push/pop/count.
REQ-034 The total RTL shall fit in 120-400 lines.

Verification
REQ-035 The bench shall instantiate sp_ram_ctrl driving a real sp_ram, plus a behavioural reference model.
REQ-036 Reset release -> req_ready=0 for 1024 cycles, then init_done=1; a read of addresses 0, 511 and 1023 shall return 32'h0.
REQ-037 Write 16 random words to addresses 0..15, then read addresses 0..15 back-to-back with rsp_ready=1 -> 16 responses, in order, matching the writes, one per cycle.
REQ-038 Hold rsp_ready=0 and issue 3 reads:
- req_ready shall drop after 2 reads are accepted;
- rsp_rdata shall stay stable;
- after rsp_ready=1, both responses shall drain in order and the third read shall then be accepted.
REQ-039 Write 32'hDEAD_BEEF to address 5, then read address 5 on the next cycle -> the response shall be 32'hDEAD_BEEF.
REQ-040 Pull rst_n low at sweep address 300, and separately with 2 responses pending:
- outputs shall return to reset values immediately;
- the sweep shall restart from address 0;
- no stale response shall appear.
REQ-041 Random valid/ready traffic for 10k cycles -> zero mismatches against the model; the FIFO assertions shall never fire.
